// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared pipeline types and encodings
//   pipe_state_e : sequencing states of pipeline_ctrl
//   NOP_INSN     : instruction word the stages load on bubble/flush
package types_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } pipe_state_e;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//   clk   in  clock
//   clear in  synchronous clear, wins over inc
//   inc   in  count up by one when not saturated
//   count out current value, holds at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/halt sequencing for the three-stage pipeline
//   in : clk, rst, haz_stall, branch_taken, mdu_start, mdu_done, halt_req
//   out: pc_en, s1_en, s2_en, s3_en, s1_flush, s2_bubble, s3_bubble (combinational)
//        halted, mdu_err, stall_count (registered)
module pipeline_ctrl
   import types_pkg::*;
#(
   parameter int MDU_TIMEOUT  = 32,
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             haz_stall,
   input  logic             branch_taken,
   input  logic             mdu_start,
   input  logic             mdu_done,
   input  logic             halt_req,
   output logic             pc_en,
   output logic             s1_en,
   output logic             s2_en,
   output logic             s3_en,
   output logic             s1_flush,
   output logic             s2_bubble,
   output logic             s3_bubble,
   output logic             halted,
   output logic             mdu_err,
   output logic [CNT_W-1:0] stall_count
);

   localparam int WAIT_W  = $clog2(MDU_TIMEOUT + 1);
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   pipe_state_e        state, state_d;
   logic [WAIT_W-1:0]  wait_cnt, wait_d;
   logic [DRAIN_W-1:0] drain_cnt, drain_d;
   logic               halt_pend, pend_d;
   logic               err_d;
   logic               stall_inc;

   always_comb begin
      state_d   = state;
      wait_d    = wait_cnt;
      drain_d   = drain_cnt;
      pend_d    = halt_pend;
      err_d     = mdu_err;
      pc_en     = 1'b1;
      s1_en     = 1'b1;
      s2_en     = 1'b1;
      s3_en     = 1'b1;
      s1_flush  = 1'b0;
      s2_bubble = 1'b0;
      s3_bubble = 1'b0;

      if (rst) begin
         pc_en = 1'b0;
         s1_en = 1'b0;
         s2_en = 1'b0;
         s3_en = 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (mdu_start) begin
                  // The MDU op must still advance into stage two this cycle.
                  state_d = MDU_WAIT;
                  wait_d  = '0;
                  if (halt_req) pend_d = 1'b1;
               end else if (halt_req || halt_pend) begin
                  pc_en     = 1'b0;
                  s1_en     = 1'b0;
                  s2_bubble = 1'b1;
                  state_d   = DRAIN;
                  drain_d   = '0;
                  pend_d    = 1'b0;
               end else if (haz_stall) begin
                  // Stage one holds, so a taken branch re-presents next cycle.
                  pc_en     = 1'b0;
                  s1_en     = 1'b0;
                  s2_bubble = 1'b1;
               end else if (branch_taken) begin
                  s1_flush = 1'b1;
               end
            end
            MDU_WAIT: begin
               if (halt_req) pend_d = 1'b1;
               if (mdu_done) begin
                  state_d = RUN;
               end else if (wait_cnt == WAIT_W'(MDU_TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = RUN;
               end else begin
                  pc_en     = 1'b0;
                  s1_en     = 1'b0;
                  s2_en     = 1'b0;
                  s3_bubble = 1'b1;
                  wait_d    = wait_cnt + 1'b1;
               end
            end
            DRAIN: begin
               pc_en     = 1'b0;
               s1_en     = 1'b0;
               s2_bubble = 1'b1;
               if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                  state_d = HALTED;
               end else begin
                  drain_d = drain_cnt + 1'b1;
               end
            end
            HALTED: begin
               pc_en = 1'b0;
               s1_en = 1'b0;
               s2_en = 1'b0;
               s3_en = 1'b0;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         wait_cnt  <= '0;
         drain_cnt <= '0;
         halt_pend <= 1'b0;
         halted    <= 1'b0;
         mdu_err   <= 1'b0;
      end else begin
         state     <= state_d;
         wait_cnt  <= wait_d;
         drain_cnt <= drain_d;
         halt_pend <= pend_d;
         halted    <= (state_d == HALTED);
         mdu_err   <= err_d;
      end
   end

   // Outputs are forced low during rst, so rst cycles must be excluded explicitly.
   assign stall_inc = !rst && !pc_en && (state != HALTED);

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (stall_inc),
      .count (stall_count)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       haz_stall, branch_taken, mdu_start, mdu_done, halt_req;
   logic       pc_en, s1_en, s2_en, s3_en, s1_flush, s2_bubble, s3_bubble;
   logic       halted, mdu_err;
   logic [3:0] stall_count;
   int         errors = 0;
   int         checks = 0;

   // {pc_en, s1_en, s2_en, s3_en, s1_flush, s2_bubble, s3_bubble}
   localparam logic [6:0] C_DEF   = 7'b1111_000;
   localparam logic [6:0] C_STALL = 7'b0011_010;
   localparam logic [6:0] C_FLUSH = 7'b1111_100;
   localparam logic [6:0] C_MWAIT = 7'b0001_001;
   localparam logic [6:0] C_OFF   = 7'b0000_000;

   pipeline_ctrl #(
      .MDU_TIMEOUT  (8),
      .DRAIN_CYCLES (2),
      .CNT_W        (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .haz_stall    (haz_stall),
      .branch_taken (branch_taken),
      .mdu_start    (mdu_start),
      .mdu_done     (mdu_done),
      .halt_req     (halt_req),
      .pc_en        (pc_en),
      .s1_en        (s1_en),
      .s2_en        (s2_en),
      .s3_en        (s3_en),
      .s1_flush     (s1_flush),
      .s2_bubble    (s2_bubble),
      .s3_bubble    (s3_bubble),
      .halted       (halted),
      .mdu_err      (mdu_err),
      .stall_count  (stall_count)
   );

   always #5 clk = ~clk;

   wire [6:0] ctrl = {pc_en, s1_en, s2_en, s3_en, s1_flush, s2_bubble, s3_bubble};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clr_in();
      haz_stall = 0; branch_taken = 0; mdu_start = 0; mdu_done = 0; halt_req = 0;
   endtask

   task automatic do_reset();
      clr_in();
      rst = 1;
      tick();
      rst = 0;
   endtask

   initial begin
      rst = 1;
      clr_in();
      haz_stall = 1; branch_taken = 1;
      settle();
      chk("ctrl_in_rst", 32'(ctrl), 32'(C_OFF));
      tick();
      tick();
      clr_in();
      rst = 0;
      settle();
      chk("rst_halted", 32'(halted), 0);
      chk("rst_err", 32'(mdu_err), 0);
      chk("rst_cnt", 32'(stall_count), 0);
      for (int i = 0; i < 5; i++) begin
         chk("idle_ctrl", 32'(ctrl), 32'(C_DEF));
         tick();
      end
      chk("idle_cnt", 32'(stall_count), 0);

      // hazard beats branch; branch re-presents next cycle
      haz_stall = 1; branch_taken = 1;
      settle();
      chk("haz_ctrl", 32'(ctrl), 32'(C_STALL));
      tick();
      haz_stall = 0;
      settle();
      chk("br_ctrl", 32'(ctrl), 32'(C_FLUSH));
      tick();
      clr_in();
      settle();
      chk("haz_cnt", 32'(stall_count), 1);

      // MDU op with done four cycles after start
      do_reset();
      mdu_start = 1;
      settle();
      chk("mdu_start_ctrl", 32'(ctrl), 32'(C_DEF));
      tick();
      mdu_start = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("mdu_wait_ctrl", 32'(ctrl), 32'(C_MWAIT));
         tick();
      end
      mdu_done = 1;
      settle();
      chk("mdu_done_ctrl", 32'(ctrl), 32'(C_DEF));
      tick();
      mdu_done = 0;
      haz_stall = 1;
      settle();
      chk("mdu_back_run", 32'(ctrl), 32'(C_STALL));
      chk("mdu_cnt", 32'(stall_count), 3);
      haz_stall = 0;

      // MDU timeout after 8 wait cycles
      do_reset();
      mdu_start = 1;
      tick();
      mdu_start = 0;
      for (int i = 0; i < 7; i++) begin
         settle();
         chk("to_wait_ctrl", 32'(ctrl), 32'(C_MWAIT));
         tick();
      end
      settle();
      chk("to_last_ctrl", 32'(ctrl), 32'(C_DEF));
      chk("to_err_pre", 32'(mdu_err), 0);
      tick();
      settle();
      chk("to_err", 32'(mdu_err), 1);
      chk("to_cnt", 32'(stall_count), 7);
      chk("to_run_ctrl", 32'(ctrl), 32'(C_DEF));
      repeat (3) tick();
      chk("to_err_sticky", 32'(mdu_err), 1);
      do_reset();
      settle();
      chk("to_err_rst", 32'(mdu_err), 0);

      // done in the timeout cycle wins
      mdu_start = 1;
      tick();
      mdu_start = 0;
      repeat (7) tick();
      mdu_done = 1;
      tick();
      mdu_done = 0;
      settle();
      chk("done_prio_err", 32'(mdu_err), 0);

      // halt: halted three edges after halt_req
      do_reset();
      halt_req = 1;
      settle();
      chk("halt_ctrl", 32'(ctrl), 32'(C_STALL));
      tick();
      halt_req = 0; haz_stall = 1; branch_taken = 1; mdu_start = 1;
      settle();
      chk("drain1_ctrl", 32'(ctrl), 32'(C_STALL));
      tick();
      settle();
      chk("drain2_ctrl", 32'(ctrl), 32'(C_STALL));
      chk("drain2_halted", 32'(halted), 0);
      tick();
      settle();
      chk("halted", 32'(halted), 1);
      chk("halted_ctrl", 32'(ctrl), 32'(C_OFF));
      repeat (3) tick();
      chk("halted_hold", 32'(halted), 1);
      chk("halted_ctrl2", 32'(ctrl), 32'(C_OFF));
      chk("halt_cnt", 32'(stall_count), 3);

      // reset in the middle of DRAIN
      do_reset();
      halt_req = 1;
      tick();
      halt_req = 0;
      rst = 1;
      tick();
      rst = 0;
      settle();
      chk("mid_rst_ctrl", 32'(ctrl), 32'(C_DEF));
      chk("mid_rst_halted", 32'(halted), 0);
      chk("mid_rst_cnt", 32'(stall_count), 0);
      repeat (3) tick();
      chk("mid_rst_halted2", 32'(halted), 0);

      // halt_req alongside mdu_start is remembered
      do_reset();
      mdu_start = 1; halt_req = 1;
      tick();
      clr_in();
      settle();
      chk("pend_wait", 32'(ctrl), 32'(C_MWAIT));
      tick();
      mdu_done = 1;
      tick();
      mdu_done = 0;
      settle();
      chk("pend_halt_ctrl", 32'(ctrl), 32'(C_STALL));
      repeat (3) tick();
      chk("pend_halted", 32'(halted), 1);

      // stall counter saturation
      do_reset();
      haz_stall = 1;
      repeat (14) tick();
      chk("sat_14", 32'(stall_count), 14);
      repeat (6) tick();
      haz_stall = 0;
      settle();
      chk("sat_15", 32'(stall_count), 15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
